// File: rtl/audio_arbiter_pkg.sv
// Shared types and default constants for the audio request arbiter.
// Imported by the interface, the watchdog and the arbiter top.
package audio_pkg;

    localparam int         ID_W_DEF      = 2;
    localparam logic [3:0] EXCL_MASK_DEF = 4'b1100;
    localparam int         TIMEOUT_DEF   = 50_000_000;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        LOCK
    } arb_state_t;

endpackage

// File: rtl/audio_arbiter_if.sv
// Request/status bundle between a sound requester and the arbiter.
// The requester drives req_id/playback_complete; the arbiter drives status.
interface audio_arbiter_if
    import audio_pkg::*;
#(
    parameter int ID_W = ID_W_DEF
);

    logic [ID_W-1:0] req_id;
    logic            playback_complete;
    logic            en;
    logic [ID_W-1:0] effective_select;
    logic            busy;
    logic            locked;
    logic            pend_valid;
    logic            dropped;
    logic            timeout;

    modport master (
        output req_id, playback_complete,
        input  en, effective_select, busy, locked,
        input  pend_valid, dropped, timeout
    );

    modport slave (
        input  req_id, playback_complete,
        output en, effective_select, busy, locked,
        output pend_valid, dropped, timeout
    );

endinterface

// File: rtl/audio_arbiter_watchdog.sv
// Playback watchdog: counts enabled cycles since the last clear and
// pulses expire (registered) in the cycle the count equals TIMEOUT_CYC-1.
module audio_watchdog
    import audio_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic cnt_en,
    output logic expire
);

    if (TIMEOUT_CYC == 0) begin : g_off
        logic unused_in;
        assign unused_in = ^{clk, reset, clear, cnt_en};
        assign expire    = 1'b0;
    end else begin : g_on
        localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
        localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC - 1);

        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;

        // Next count: clear restarts at zero, counting saturates at the limit
        always_comb begin
            cnt_nxt = cnt;
            if (clear) begin
                cnt_nxt = '0;
            end else if (cnt_en && (cnt != LIM)) begin
                cnt_nxt = cnt + CW'(1);
            end
        end

        // Count register and the one-cycle expiry flag
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt    <= '0;
                expire <= 1'b0;
            end else begin
                cnt    <= cnt_nxt;
                expire <= (clear || cnt_en) && (cnt_nxt == LIM);
            end
        end
    end

endmodule

// File: rtl/audio_arbiter.sv
// Audio request arbiter: plays, preempts or locks out sound IDs.
// Optional one-entry pending slot for LOCK requests: AUDIO_ARB_QUEUE_EN.
module audio_arbiter
    import audio_pkg::*;
#(
    parameter int                 ID_W        = ID_W_DEF,
    parameter logic [2**ID_W-1:0] EXCL_MASK   = EXCL_MASK_DEF,
    parameter int                 TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    audio_arbiter_if.slave  bus
);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [ID_W-1:0] req_q;
    logic [ID_W-1:0] pend_id;
    logic [ID_W-1:0] pend_id_nxt;
    logic [ID_W-1:0] sel_nxt;
    logic [ID_W-1:0] start_id;
    logic            pend_v;
    logic            pv_nxt;
    logic            en_nxt;
    logic            drop_nxt;
    logic            start;
    logic            req_evt;
    logic            done;
    logic            wd_expire;

    assign req_evt = (bus.req_id != '0) && (bus.req_id != req_q);
    assign done    = (state != IDLE) && (bus.playback_complete || wd_expire);

    assign bus.busy    = (state != IDLE);
    assign bus.locked  = (state == LOCK);
    assign bus.timeout = wd_expire;

`ifdef AUDIO_ARB_QUEUE_EN
    assign bus.pend_valid = pend_v;
`else
    assign bus.pend_valid = 1'b0;
`endif

    // Next state, selection, pending slot and drop decision
    always_comb begin
        state_nxt   = state;
        sel_nxt     = bus.effective_select;
        en_nxt      = bus.en;
        pv_nxt      = pend_v;
        pend_id_nxt = pend_id;
        drop_nxt    = 1'b0;
        start       = 1'b0;
        start_id    = bus.req_id;
        unique case (state)
            IDLE: begin
                if (pend_v) begin
                    start    = 1'b1;
                    start_id = pend_id;
                    pv_nxt   = 1'b0;
                    drop_nxt = req_evt;
                end else if (req_evt) begin
                    start = 1'b1;
                end
            end
            PLAY: begin
                if (req_evt) begin
                    start = 1'b1;
                end else if (done) begin
                    en_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            LOCK: begin
`ifdef AUDIO_ARB_QUEUE_EN
                if (req_evt) begin
                    drop_nxt    = pend_v;
                    pv_nxt      = 1'b1;
                    pend_id_nxt = bus.req_id;
                end
`else
                drop_nxt = req_evt;
`endif
                if (done) begin
                    en_nxt    = 1'b0;
                    sel_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (start) begin
            sel_nxt   = start_id;
            en_nxt    = 1'b1;
            state_nxt = EXCL_MASK[start_id] ? LOCK : PLAY;
        end
    end

    // Registered state and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            req_q                <= '0;
            pend_v               <= 1'b0;
            pend_id              <= '0;
            bus.en               <= 1'b0;
            bus.effective_select <= '0;
            bus.dropped          <= 1'b0;
        end else begin
            state                <= state_nxt;
            req_q                <= bus.req_id;
            pend_v               <= pv_nxt;
            pend_id              <= pend_id_nxt;
            bus.en               <= en_nxt;
            bus.effective_select <= sel_nxt;
            bus.dropped          <= drop_nxt;
        end
    end

    audio_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .cnt_en (state_nxt != IDLE),
        .expire (wd_expire)
    );

endmodule

// File: doc/audio_arbiter.md
AUDIO_ARBITER -- requirements
Module: audio_arbiter

Interface
REQ-001 SHALL have parameter ID_W, default 2: sound-ID width; ID 0 means "no sound".
REQ-002 SHALL have parameter EXCL_MASK [2**ID_W-1:0], default 4'b1100: bit k set makes ID k exclusive (lock-out until done).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50_000_000: watchdog limit in clk cycles; 0 disables the watchdog.
REQ-004 SHALL have port clk, input, 1: clock, all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port req_id, input, ID_W: requested sound, level input.
REQ-007 SHALL have port playback_complete, input, 1: one-cycle pulse from the player.
REQ-008 SHALL have port en, output, 1: player enable.
REQ-009 SHALL have port effective_select, output, ID_W: ID passed to the player.
REQ-010 SHALL have port busy, output, 1: state is not IDLE.
REQ-011 SHALL have port locked, output, 1: state is LOCK.
REQ-012 SHALL have port pend_valid, output, 1: pending slot occupied.
REQ-013 SHALL have port dropped, output, 1: one-cycle pulse when a request is discarded.
REQ-014 SHALL have port timeout, output, 1: one-cycle pulse when the watchdog fires.

Function
REQ-015 SHALL register req_id into req_q each cycle; req_evt = (req_id != 0) && (req_id != req_q).
REQ-016 SHALL implement states IDLE, PLAY and LOCK, all outputs registered.
REQ-017 "Start X" SHALL mean: on the next edge effective_select<=X, en<=1, watchdog cleared, state<=LOCK if EXCL_MASK[X] else PLAY.
REQ-018 IDLE SHALL start the pending ID if pend_valid (clearing the slot), else start req_id on req_evt; when both exist, pending wins and the req_evt counts as dropped.
REQ-019 PLAY SHALL start req_id on req_evt (preemption, no en gap); on done without req_evt, en<=0, effective_select held, state<=IDLE.
REQ-020 In PLAY, req_evt and done in the same cycle SHALL resolve to req_evt wins.
REQ-021 LOCK SHALL never start a new ID; on done, en<=0, effective_select<=0, state<=IDLE.
REQ-022 done SHALL be playback_complete OR watchdog expiry; playback_complete in IDLE SHALL be ignored.
REQ-023 The watchdog SHALL count cycles while busy and expire when count reaches TIMEOUT_CYC-1, asserting timeout for exactly that cycle.
REQ-024 dropped SHALL pulse for every req_evt not started or stored, and for every pending overwrite.
REQ-025 Holding a non-zero req_id after completion SHALL NOT retrigger; re-triggering the same ID requires req_id to change first.

Reset
REQ-026 Reset SHALL asynchronously clear en, effective_select, req_q, pending slot, watchdog, busy, locked, pend_valid, dropped and timeout to 0, and set state to IDLE.
REQ-027 Reset mid-playback SHALL drop the active and pending IDs with no dropped pulse.
REQ-028 Operation SHALL resume on the first edge after reset deasserts.

Configuration
REQ-029 Macro AUDIO_ARB_QUEUE_EN SHALL control the one-entry pending slot.
REQ-030 With AUDIO_ARB_QUEUE_EN defined, a req_evt in LOCK SHALL store req_id in the slot, overwriting any older entry and pulsing dropped.
REQ-031 Without AUDIO_ARB_QUEUE_EN, a req_evt in LOCK SHALL be discarded with dropped pulsed, and pend_valid SHALL be tied to 0.

Structure
REQ-032 Package audio_pkg SHALL hold the state enum (IDLE, PLAY, LOCK) and the default constants for ID_W, EXCL_MASK and TIMEOUT_CYC.
REQ-033 The watchdog SHALL be a sub-module audio_watchdog (clear, count-enable, expire pulse), parameterised by TIMEOUT_CYC; all counter widths SHALL be derived with $clog2.

Verification
REQ-034 Bench defaults SHALL be ID_W=2, EXCL_MASK=4'b1100, TIMEOUT_CYC=16, with AUDIO_ARB_QUEUE_EN defined unless a scenario says otherwise.
REQ-035 req_id 0->1 -> next edge en=1, sel=1, PLAY; playback_complete -> en=0, sel=1, IDLE; req_id held at 1 -> no restart.
REQ-036 Playing ID 1, then req_id=3 -> sel=3, en stays 1, locked=1; req_id=1 during LOCK -> pend_valid=1; complete -> sel=0, then the following cycle sel=1, en=1.
REQ-037 In LOCK with queue: req 1, 0, 2 -> dropped pulses once on the 2 overwrite and the slot holds 2; without AUDIO_ARB_QUEUE_EN -> dropped pulses twice and pend_valid stays 0.
REQ-038 Start ID 2 with no playback_complete -> timeout pulses 15 cycles after start, sel=0, IDLE; with TIMEOUT_CYC=0 -> LOCK is held indefinitely.
REQ-039 In PLAY, req_evt=2 and playback_complete in the same cycle -> sel=2, en=1, LOCK.
REQ-040 Assert reset in LOCK with pend_valid=1 -> all outputs 0 immediately, with no dropped pulse.
